instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 32-bit MIPS core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK and drives the datapath strobes: PC write and source select, IR load, ALU enable, register-file write, and the shared memory port request. It sits beside the decode control unit, consuming the 2-bit instruction type and decode flags. It owns the single memory port: instruction fetch and data access never overlap.

---
 rtl/instr_sequencer_if.sv | 39 +++
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer and the decode/datapath/memory side.
// master = sequencer (drives strobes), slave = surrounding core that feeds decode flags and mem_ack.
interface instr_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [1:0]       instr_type;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             branch_taken;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_sel;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_en;
    logic             rf_we;
    logic [2:0]       state;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instret;

    // mem_req/mem_ack: a request stays up until mem_ack is seen in the same cycle;
    // the transfer completes on that cycle's rising clock edge.
    modport master (
        input  start, instr_type, is_load, is_store, is_branch, branch_taken, mem_ack,
        output mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, alu_en, rf_we,
               state, halted, err, instret
    );

    modport slave (
        output start, instr_type, is_load, is_store, is_branch, branch_taken, mem_ack,
        input  mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, alu_en, rf_we,
               state, halted, err, instret
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with one shared memory port,
// per-request ack timeout and a retired-instruction counter.
module instr_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [1:0] T_R    = 2'd0;
    localparam logic [1:0] T_J    = 2'd1;
    localparam logic [1:0] T_HALT = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic       mem_req, mem_sel, mem_we, ir_we, pc_we, alu_en, rf_we, halted, err;
    logic [1:0] pc_src;
    logic       retire;
    logic       timeout_hit;

    // The wait counter reaching TIMEOUT-1 with no ack means this was the last allowed cycle.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !bus.mem_ack;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_sel = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = PC_PLUS4;
        alu_en  = 1'b0;
        rf_we   = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                state_d = (bus.instr_type == T_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (bus.instr_type == T_J) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (bus.instr_type == T_R) begin
                    state_d = S_WB;
                end else if (bus.is_load || bus.is_store) begin
                    state_d = S_MEM;
                end else if (bus.is_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = bus.branch_taken ? PC_BRANCH : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                // Load wins if decode ever flags both.
                mem_we  = bus.is_store && !bus.is_load;
                if (bus.mem_ack) begin
                    if (bus.is_store && !bus.is_load) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
                halted = 1'b1;
                err    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            wait_d = '0;
        else if (mem_req && !bus.mem_ack)
            wait_d = wait_q + WAIT_W'(1);
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign bus.mem_req = mem_req;
    assign bus.mem_sel = mem_sel;
    assign bus.mem_we  = mem_we;
    assign bus.ir_we   = ir_we;
    assign bus.pc_we   = pc_we;
    assign bus.pc_src  = pc_src;
    assign bus.alu_en  = alu_en;
    assign bus.rf_we   = rf_we;
    assign bus.halted  = halted;
    assign bus.err     = err;
    assign bus.state   = state_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Cycle-by-cycle vector bench for instr_sequencer (TIMEOUT=4, 3-bit instret so wrap is reachable).
module tb_instr_sequencer;
    logic clk;
    logic rst_n;

    instr_sequencer_if #(.CNT_W(3)) bus ();

    instr_sequencer #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input bits: start, type[1:0], load, store, branch, taken, ack
    localparam logic [7:0] START = 8'h80;
    localparam logic [7:0] T_R   = 8'h00;
    localparam logic [7:0] T_J   = 8'h20;
    localparam logic [7:0] T_HLT = 8'h40;
    localparam logic [7:0] T_I   = 8'h60;
    localparam logic [7:0] LD    = 8'h10;
    localparam logic [7:0] ST    = 8'h08;
    localparam logic [7:0] BR    = 8'h04;
    localparam logic [7:0] TK    = 8'h02;
    localparam logic [7:0] ACK   = 8'h01;
    localparam logic [7:0] NONE  = 8'h00;

    // Output bits: req, sel, we, ir_we, pc_we, pc_src[1:0], alu_en, rf_we, halted, err
    localparam logic [10:0] O_NONE = 11'h000;
    localparam logic [10:0] REQ    = 11'h400;
    localparam logic [10:0] SEL    = 11'h200;
    localparam logic [10:0] WE     = 11'h100;
    localparam logic [10:0] IRW    = 11'h080;
    localparam logic [10:0] PCW    = 11'h040;
    localparam logic [10:0] SRC_J  = 11'h020;
    localparam logic [10:0] SRC_BR = 11'h010;
    localparam logic [10:0] ALU    = 11'h008;
    localparam logic [10:0] RFW    = 11'h004;
    localparam logic [10:0] HLT    = 11'h002;
    localparam logic [10:0] ERR    = 11'h001;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_ERR  = 3'd7;

    typedef struct {
        logic        rst_n;
        logic [7:0]  in;
        logic [2:0]  st;
        logic [10:0] strb;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [7:0] i, input logic [2:0] s,
                       input logic [10:0] o, input logic [2:0] c);
        vec_t v;
        v.rst_n = r;
        v.in    = i;
        v.st    = s;
        v.strb  = o;
        v.cnt   = c;
        vecs.push_back(v);
    endtask

    // Instruction fetched with a zero-wait ack; instret shown is the pre-edge value.
    task automatic add_fetch(input logic [2:0] c);
        add(1'b1, ACK, S_FETCH, REQ | IRW, c);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL vec%0d %s got=%0h exp=%0h", idx, name, got, exp);
        end
    endtask

    initial begin
        logic [10:0] got_strb;

        rst_n = 1'b0;
        {bus.start, bus.instr_type, bus.is_load, bus.is_store,
         bus.is_branch, bus.branch_taken, bus.mem_ack} = 8'h00;

        // Reset and idle
        add(1'b0, NONE, S_IDLE, O_NONE, 3'd0);
        add(1'b0, NONE, S_IDLE, O_NONE, 3'd0);
        for (int k = 0; k < 10; k++) add(1'b1, NONE, S_IDLE, O_NONE, 3'd0);
        add(1'b1, START, S_IDLE, O_NONE, 3'd0);
        // R-type then J-type, zero-wait memory
        add_fetch(3'd0);
        add(1'b1, T_R, S_DECODE, O_NONE, 3'd0);
        add(1'b1, T_R, S_EXEC, ALU, 3'd0);
        add(1'b1, T_R, S_WB, RFW | PCW, 3'd0);
        add_fetch(3'd1);
        add(1'b1, T_J, S_DECODE, O_NONE, 3'd1);
        add(1'b1, T_J, S_EXEC, ALU | PCW | SRC_J, 3'd1);
        // Load with three wait cycles in MEM
        add_fetch(3'd2);
        add(1'b1, T_I | LD, S_DECODE, O_NONE, 3'd2);
        add(1'b1, T_I | LD, S_EXEC, ALU, 3'd2);
        for (int k = 0; k < 3; k++) add(1'b1, T_I | LD, S_MEM, REQ | SEL, 3'd2);
        add(1'b1, T_I | LD | ACK, S_MEM, REQ | SEL, 3'd2);
        add(1'b1, T_I | LD, S_WB, RFW | PCW, 3'd2);
        // Store with one wait cycle
        add_fetch(3'd3);
        add(1'b1, T_I | ST, S_DECODE, O_NONE, 3'd3);
        add(1'b1, T_I | ST, S_EXEC, ALU, 3'd3);
        add(1'b1, T_I | ST, S_MEM, REQ | SEL | WE, 3'd3);
        add(1'b1, T_I | ST | ACK, S_MEM, REQ | SEL | WE | PCW, 3'd3);
        // Asynchronous reset while a fetch is outstanding; start ignored under reset
        add(1'b1, NONE, S_FETCH, REQ, 3'd4);
        add(1'b0, NONE, S_IDLE, O_NONE, 3'd0);
        add(1'b0, START, S_IDLE, O_NONE, 3'd0);
        add(1'b1, START, S_IDLE, O_NONE, 3'd0);
        // Branch taken, branch not taken, ALU-immediate
        add_fetch(3'd0);
        add(1'b1, T_I | BR, S_DECODE, O_NONE, 3'd0);
        add(1'b1, T_I | BR | TK, S_EXEC, ALU | PCW | SRC_BR, 3'd0);
        add_fetch(3'd1);
        add(1'b1, T_I | BR, S_DECODE, O_NONE, 3'd1);
        add(1'b1, T_I | BR, S_EXEC, ALU | PCW, 3'd1);
        add_fetch(3'd2);
        add(1'b1, T_I, S_DECODE, O_NONE, 3'd2);
        add(1'b1, T_I, S_EXEC, ALU, 3'd2);
        add(1'b1, T_I, S_WB, RFW | PCW, 3'd2);
        // Jumps until the 3-bit counter wraps 7 -> 0
        for (int k = 3; k < 8; k++) begin
            add_fetch(3'(k));
            add(1'b1, T_J, S_DECODE, O_NONE, 3'(k));
            add(1'b1, T_J, S_EXEC, ALU | PCW | SRC_J, 3'(k));
        end
        // Fetch acked in the last allowed cycle, then HALT (ack in DECODE ignored)
        for (int k = 0; k < 3; k++) add(1'b1, NONE, S_FETCH, REQ, 3'd0);
        add_fetch(3'd0);
        add(1'b1, T_HLT | ACK, S_DECODE, O_NONE, 3'd0);
        for (int k = 0; k < 3; k++) add(1'b1, START | ACK, S_HALT, HLT, 3'd0);
        add(1'b0, NONE, S_IDLE, O_NONE, 3'd0);
        add(1'b1, START, S_IDLE, O_NONE, 3'd0);
        // Fetch never acked: ERR after four request cycles
        for (int k = 0; k < 4; k++) add(1'b1, NONE, S_FETCH, REQ, 3'd0);
        add(1'b1, START | ACK, S_ERR, HLT | ERR, 3'd0);
        add(1'b1, START | ACK, S_ERR, HLT | ERR, 3'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            {bus.start, bus.instr_type, bus.is_load, bus.is_store,
             bus.is_branch, bus.branch_taken, bus.mem_ack} = vecs[i].in;
            #1;
            got_strb = {bus.mem_req, bus.mem_sel, bus.mem_we, bus.ir_we, bus.pc_we,
                        bus.pc_src, bus.alu_en, bus.rf_we, bus.halted, bus.err};
            check("state",   i, 32'(bus.state),   32'(vecs[i].st));
            check("strobes", i, 32'(got_strb),    32'(vecs[i].strb));
            check("instret", i, 32'(bus.instret), 32'(vecs[i].cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
